// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int WIDTH = 6;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester and response channels of the ALU arbiter. All channels use valid/ready:
// a transfer happens on a rising edge where both are high; a source holding valid keeps its payload stable.
interface alu_req_arbiter_if;
    import alu_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OP_W-1:0]  req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OP_W-1:0]  req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant moves only on the advance strobe (an accepted request).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, fixed-latency wait, valid/ready response.
// Optional macro ALU_ARB_ZFLAG_EN adds the registered rsp_zero flag.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_req_arbiter_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_ARB_ZFLAG_EN
    output logic             rsp_zero,
`endif
    output state_t           dbg_state
);

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       done;
    logic       rsp_fire;

    // Requests are only offered to the arbiter while idle, so gnt doubles as ready.
    assign req = (state == IDLE) ? {bus.req1_valid, bus.req0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign accept         = |gnt;
    assign done           = (state == EXEC) && (cnt == LAT_M1);
    assign rsp_fire       = bus.rsp_valid && bus.rsp_ready;
    assign dbg_state      = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:    if (done)     state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= gnt[1] ? bus.req1_a  : bus.req0_a;
                alu_b      <= gnt[1] ? bus.req1_b  : bus.req0_b;
                alu_op     <= gnt[1] ? bus.req1_op : bus.req0_op;
                bus.rsp_id <= gnt[1];
                cnt        <= 3'd0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 3'd1;
            end
            if (done) begin
                bus.rsp_result <= alu_result;
                bus.rsp_valid  <= 1'b1;
            end
            if (rsp_fire) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_ZFLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero <= 1'b0;
        end else if (done) begin
            rsp_zero <= (alu_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a 1-cycle-latency instance for most scenarios and a 3-cycle one for latency.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_req_arbiter_if bus1();
    alu_req_arbiter_if bus3();

    logic [WIDTH-1:0] alu_a1, alu_b1, alu_res1, alu_a3, alu_b3, alu_res3;
    logic [WIDTH-1:0] pipe3_s1 = '0;
    logic [WIDTH-1:0] pipe3_s2 = '0;
    logic [OP_W-1:0]  alu_op1, alu_op3;
    state_t           st1, st3;
`ifdef ALU_ARB_ZFLAG_EN
    logic             zero1, zero3;
`endif

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] exp_q[$];

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [OP_W-1:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOTA: return ~a;
            default: return b;
        endcase
    endfunction

    // Clock / reset and ALU models: combinational ALU for latency 1, two register stages for latency 3.
    always #5 clk = ~clk;
    assign alu_res1 = alu_fn(alu_a1, alu_b1, alu_op1);
    always @(posedge clk) begin
        pipe3_s1 <= alu_fn(alu_a3, alu_b3, alu_op3);
        pipe3_s2 <= pipe3_s1;
    end
    assign alu_res3 = pipe3_s2;

    alu_req_arbiter #(.ALU_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_res1),
`ifdef ALU_ARB_ZFLAG_EN
        .rsp_zero(zero1),
`endif
        .dbg_state(st1)
    );

    alu_req_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_res3),
`ifdef ALU_ARB_ZFLAG_EN
        .rsp_zero(zero3),
`endif
        .dbg_state(st3)
    );

    // Driver tasks
    task automatic idle_inputs;
        bus1.req0_valid = 0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_op = '0;
        bus1.req1_valid = 0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_op = '0;
        bus1.rsp_ready  = 0;
        bus3.req0_valid = 0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_op = '0;
        bus3.req1_valid = 0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_op = '0;
        bus3.rsp_ready  = 0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus1.rsp_valid); end
        checks++; if (bus1.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0b exp=0", bus1.rsp_id); end
        checks++; if (bus1.rsp_result !== 6'd0) begin errors++; $display("FAIL reset_rsp_result got=%0h exp=0", bus1.rsp_result); end
        checks++; if ({alu_a1, alu_b1, alu_op1} !== 15'd0) begin errors++; $display("FAIL reset_alu_regs got=%0h/%0h/%0h exp=0", alu_a1, alu_b1, alu_op1); end
        checks++; if (st1 !== IDLE || st3 !== IDLE) begin errors++; $display("FAIL reset_state got=%0d/%0d exp=%0d", st1, st3, IDLE); end
        checks++; if (bus3.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid3 got=%0b exp=0", bus3.rsp_valid); end
`ifdef ALU_ARB_ZFLAG_EN
        checks++; if (zero1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got=%0b exp=0", zero1); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single_op;
        @(negedge clk);
        bus1.req0_a = 6'b101010; bus1.req0_b = 6'b110011; bus1.req0_op = OP_XNOR; bus1.req0_valid = 1;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1 || bus1.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%0b%0b exp=01", bus1.req1_ready, bus1.req0_ready); end
        @(negedge clk); #1;
        checks++; if (bus1.req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_exec got=%0b exp=0", bus1.req0_ready); end
        checks++; if ({alu_a1, alu_b1, alu_op1} !== {6'b101010, 6'b110011, OP_XNOR}) begin errors++; $display("FAIL single_alu_regs got=%0h/%0h/%0h exp=2a/33/3", alu_a1, alu_b1, alu_op1); end
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got=%0b exp=0", bus1.rsp_valid); end
        bus1.req0_valid = 0;
        @(negedge clk); #1;
        checks++; if (bus1.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%0b exp=1", bus1.rsp_valid); end
        checks++; if (bus1.rsp_result !== 6'b100110) begin errors++; $display("FAIL single_rsp_result got=%0b exp=100110", bus1.rsp_result); end
        checks++; if (bus1.rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got=%0b exp=0", bus1.rsp_id); end
`ifdef ALU_ARB_ZFLAG_EN
        checks++; if (zero1 !== 1'b0) begin errors++; $display("FAIL single_rsp_zero got=%0b exp=0", zero1); end
`endif
        bus1.rsp_ready = 1;
        @(negedge clk); #1;
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got=%0b exp=0", bus1.rsp_valid); end
        bus1.rsp_ready = 0;
    endtask

    task automatic test_contention;
        int grants[$];
        int ids[$];
        pulse_reset();
        bus1.req0_a = 6'd3; bus1.req0_b = 6'd5; bus1.req0_op = OP_ADD; bus1.req0_valid = 1;
        bus1.req1_a = 6'd9; bus1.req1_b = 6'd4; bus1.req1_op = OP_SUB; bus1.req1_valid = 1;
        bus1.rsp_ready = 1;
        for (int cyc = 0; cyc < 60 && ids.size() < 4; cyc++) begin
            #1;
            checks++; if (bus1.req0_ready && bus1.req1_ready) begin errors++; $display("FAIL contention_both_ready got=11 exp=one-hot"); end
            if (bus1.req0_ready) grants.push_back(0);
            if (bus1.req1_ready) grants.push_back(1);
            if (bus1.rsp_valid) begin
                ids.push_back(int'(bus1.rsp_id));
                checks++;
                if (bus1.rsp_result !== (bus1.rsp_id ? alu_fn(6'd9, 6'd4, OP_SUB) : alu_fn(6'd3, 6'd5, OP_ADD))) begin
                    errors++; $display("FAIL contention_result id=%0b got=%0d", bus1.rsp_id, bus1.rsp_result);
                end
            end
            if (ids.size() == 4) begin
                bus1.req0_valid = 0;
                bus1.req1_valid = 0;
            end
            @(negedge clk);
        end
        checks++; if (ids.size() != 4 || grants.size() != 4) begin errors++; $display("FAIL contention_count got=%0d/%0d exp=4/4", grants.size(), ids.size()); end
        for (int i = 0; i < 4 && i < ids.size() && i < grants.size(); i++) begin
            checks++; if (grants[i] != i % 2 || ids[i] != i % 2) begin errors++; $display("FAIL contention_order idx=%0d got=%0d/%0d exp=%0d", i, grants[i], ids[i], i % 2); end
        end
        repeat (2) @(negedge clk);
        bus1.rsp_ready = 0;
    endtask

    task automatic test_backpressure;
        int n;
        bus1.req0_a = 6'd7; bus1.req0_b = 6'd2; bus1.req0_op = OP_OR; bus1.req0_valid = 1;
        bus1.rsp_ready = 0;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0 got=%0b exp=1", bus1.req0_ready); end
        @(negedge clk);
        bus1.req0_valid = 0;
        bus1.req1_a = 6'h0f; bus1.req1_b = 6'h2a; bus1.req1_op = OP_NOTA; bus1.req1_valid = 1;
        for (n = 0; n < 10 && !bus1.rsp_valid; n++) @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got=%0b exp=1", bus1.rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 1'b0 || bus1.rsp_result !== 6'd7 || bus1.req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%0b id=%0b r=%0d rdy1=%0b exp v=1 id=0 r=7 rdy1=0", i, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.req1_ready);
            end
            @(negedge clk);
        end
        bus1.rsp_ready = 1;
        #1;
        checks++; if (bus1.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_during_hs got=%0b exp=0", bus1.req1_ready); end
        @(negedge clk);
        bus1.rsp_ready = 0;
        #1;
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs got v=%0b rdy1=%0b exp v=0 rdy1=1", bus1.rsp_valid, bus1.req1_ready); end
        @(negedge clk); #1;
        bus1.req1_valid = 0;
        checks++; if (alu_a1 !== 6'h0f || alu_op1 !== OP_NOTA) begin errors++; $display("FAIL bp_req1_latched got=%0h/%0h exp=0f/6", alu_a1, alu_op1); end
        for (n = 0; n < 10 && !bus1.rsp_valid; n++) @(negedge clk);
        #1;
        checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 1'b1 || bus1.rsp_result !== 6'h30) begin errors++; $display("FAIL bp_req1_rsp got v=%0b id=%0b r=%0h exp v=1 id=1 r=30", bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result); end
        bus1.rsp_ready = 1;
        @(negedge clk);
        bus1.rsp_ready = 0;
    endtask

    task automatic test_latency;
        int lat;
        @(negedge clk);
        bus3.req1_a = 6'd20; bus3.req1_b = 6'd7; bus3.req1_op = OP_ADD; bus3.req1_valid = 1;
        #1;
        checks++; if (bus3.req1_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got=%0b exp=1", bus3.req1_ready); end
        @(negedge clk);
        bus3.req1_valid = 0;
        lat = 1;
        while (!bus3.rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL lat_cycles got=%0d exp=4", lat); end
        checks++; if (bus3.rsp_result !== 6'd27 || bus3.rsp_id !== 1'b1) begin errors++; $display("FAIL lat_result got=%0d id=%0b exp=27 id=1", bus3.rsp_result, bus3.rsp_id); end
        bus3.rsp_ready = 1;
        @(negedge clk); #1;
        checks++; if (bus3.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_rsp_drop got=%0b exp=0", bus3.rsp_valid); end
        bus3.rsp_ready = 0;
    endtask

    task automatic test_reset_mid_op;
        int seen;
        int n;
        @(negedge clk);
        bus1.req0_a = 6'h11; bus1.req0_b = 6'h22; bus1.req0_op = OP_PASSB; bus1.req0_valid = 1;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept got=%0b exp=1", bus1.req0_ready); end
        @(negedge clk);
        bus1.req0_valid = 0;
        #1;
        checks++; if (st1 !== EXEC) begin errors++; $display("FAIL rst_mid_in_exec got=%0d exp=%0d", st1, EXEC); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus1.rsp_valid !== 0 || bus1.rsp_id !== 0 || bus1.rsp_result !== 0 || alu_a1 !== 0 || alu_b1 !== 0 || alu_op1 !== 0 || st1 !== IDLE) begin
            errors++; $display("FAIL rst_mid_outputs got v=%0b id=%0b r=%0h a=%0h b=%0h op=%0h st=%0d exp all 0", bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, alu_a1, alu_b1, alu_op1, st1);
        end
        reset = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus1.rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", seen); end
        bus1.req0_a = 6'd1; bus1.req0_b = 6'd2; bus1.req0_op = OP_ADD; bus1.req0_valid = 1;
        bus1.req1_a = 6'd5; bus1.req1_b = 6'd5; bus1.req1_op = OP_AND; bus1.req1_valid = 1;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1 || bus1.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_first_grant got=%0b%0b exp=01", bus1.req1_ready, bus1.req0_ready); end
        @(negedge clk);
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        for (n = 0; n < 10 && !bus1.rsp_valid; n++) @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 1'b0 || bus1.rsp_result !== 6'd3) begin errors++; $display("FAIL rst_mid_rsp got v=%0b id=%0b r=%0d exp v=1 id=0 r=3", bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result); end
        bus1.rsp_ready = 1;
        @(negedge clk);
        bus1.rsp_ready = 0;
    endtask

`ifdef ALU_ARB_ZFLAG_EN
    task automatic test_zflag;
        logic [OP_W-1:0] ops [2];
        int n;
        ops[0] = OP_XOR;
        ops[1] = OP_OR;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus1.req0_a = 6'h15; bus1.req0_b = 6'h15; bus1.req0_op = ops[k]; bus1.req0_valid = 1;
            @(negedge clk);
            bus1.req0_valid = 0;
            for (n = 0; n < 10 && !bus1.rsp_valid; n++) @(negedge clk);
            #1;
            checks++; if (bus1.rsp_result !== (k == 0 ? 6'h00 : 6'h15)) begin errors++; $display("FAIL zflag_result k=%0d got=%0h", k, bus1.rsp_result); end
            checks++; if (zero1 !== (k == 0)) begin errors++; $display("FAIL zflag_zero k=%0d got=%0b exp=%0b", k, zero1, k == 0); end
            bus1.rsp_ready = 1;
            @(negedge clk);
            bus1.rsp_ready = 0;
        end
    endtask
`endif

    // Transaction-level model: grant by rule, responses from a queue, response due LAT+1 cycles after accept.
    task automatic test_random;
        logic             hold [2];
        logic [WIDTH-1:0] ra [2];
        logic [WIDTH-1:0] rb [2];
        logic [OP_W-1:0]  rop [2];
        int ref_last;
        int g;
        int age;
        logic busy;
        logic exp_v;
        pulse_reset();
        exp_q.delete();
        ref_last = 1; busy = 0; age = 0;
        hold[0] = 0; hold[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    hold[i] = ($urandom_range(0, 9) < 4);
                    ra[i] = WIDTH'($urandom); rb[i] = WIDTH'($urandom); rop[i] = OP_W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    hold[i] = 0;
                end
            end
            bus1.req0_valid = hold[0]; bus1.req0_a = ra[0]; bus1.req0_b = rb[0]; bus1.req0_op = rop[0];
            bus1.req1_valid = hold[1]; bus1.req1_a = ra[1]; bus1.req1_b = rb[1]; bus1.req1_op = rop[1];
            bus1.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (busy) begin
                exp_v = (age >= 2);
                checks++; if (bus1.req0_ready || bus1.req1_ready) begin errors++; $display("FAIL rand_ready_busy cyc=%0d got=%0b%0b exp=00", cyc, bus1.req1_ready, bus1.req0_ready); end
                checks++; if (bus1.rsp_valid !== exp_v) begin errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%0b exp=%0b", cyc, bus1.rsp_valid, exp_v); end
                if (bus1.rsp_valid && exp_q.size() > 0) begin
                    checks++; if ({bus1.rsp_id, bus1.rsp_result} !== exp_q[0]) begin errors++; $display("FAIL rand_rsp cyc=%0d got=%0h exp=%0h", cyc, {bus1.rsp_id, bus1.rsp_result}, exp_q[0]); end
                end
                if (bus1.rsp_valid && bus1.rsp_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    busy = 0;
                end
                age++;
            end else begin
                if (hold[0] && hold[1]) g = 1 - ref_last;
                else if (hold[0])       g = 0;
                else if (hold[1])       g = 1;
                else                    g = -1;
                checks++; if (bus1.req0_ready !== (g == 0) || bus1.req1_ready !== (g == 1)) begin errors++; $display("FAIL rand_grant cyc=%0d got=%0b%0b exp_gnt=%0d", cyc, bus1.req1_ready, bus1.req0_ready, g); end
                checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_rsp_idle cyc=%0d got=%0b exp=0", cyc, bus1.rsp_valid); end
                if (g >= 0) begin
                    exp_q.push_back({g[0], alu_fn(ra[g], rb[g], rop[g])});
                    ref_last = g;
                    hold[g] = 0;
                    busy = 1;
                    age = 1;
                end
            end
        end
        @(negedge clk);
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.rsp_ready = 1;
        repeat (4) @(negedge clk);
        bus1.rsp_ready = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_latency();
        test_reset_mid_op();
`ifdef ALU_ARB_ZFLAG_EN
        test_zflag();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
